qtree_job_sequencer: RTL and testbench
======================================

QTREE_JOB_SEQUENCER -- requirements
Module: qtree_job_sequencer

Interface
REQ-001 Parameters SHALL be: DATA_W, 67, operand token width; MASK_W, 67, mask token width; PTR_W, 32, result pointer width; CNT_W, 32, cycle counter width; TIMEOUT_CYCLES, 100000, watchdog limit.
REQ-002 aclk  in  1  clock; all logic rising-edge.
REQ-003 aresetn  in  1  reset, synchronous, active-low; clock aclk.
REQ-004 start  in  1  job request pulse; busy  out  1  job in progress; done  out  1  one-cycle completion pulse; err  out  1  sticky timeout flag.
REQ-005 a_tdata/a_tlast/a_tvalid  in  DATA_W/1/1, a_tready  out  1  operand-A tree stream.
REQ-006 b_tdata/b_tlast/b_tvalid  in  DATA_W/1/1, b_tready  out  1  operand-B tree stream.
REQ-007 m_tdata/m_tlast/m_tvalid  in  MASK_W/1/1, m_tready  out  1  mask tree stream.
REQ-008 k_tdata/k_tlast/k_tvalid  out  DATA_W/1/1, k_tready  in  1  shared kernel operand port.
REQ-009 km_tdata/km_tlast/km_tvalid  out  MASK_W/1/1, km_tready  in  1  kernel mask port.
REQ-010 r_tdata  in  PTR_W  kernel result; bit 0 = result valid. r_tready  out  1.
REQ-011 result_ptr  out  PTR_W  captured result; cycles  out  CNT_W  job latency.

Function
REQ-012 FSM states SHALL be IDLE, SEND_A, SEND_B, WAIT_RES, DONE, ERR.
REQ-013 IDLE: start=1 -> SEND_A next cycle; busy=1 in every state except IDLE; start ignored outside IDLE.
REQ-014 SEND_A: k_* = a_* combinationally, a_tready = k_tready; a_tvalid&a_tready&a_tlast -> SEND_B.
REQ-015 SEND_B: k_* = b_* combinationally, b_tready = k_tready; b_tvalid&b_tready&b_tlast -> WAIT_RES.
REQ-016 Unselected operand port: tready=0; k_tvalid=0 outside SEND_A/SEND_B; no token dropped or duplicated.
REQ-017 Mask: km_* = m_*, m_tready = km_tready in SEND_A/SEND_B/WAIT_RES until mask tlast handshake sets mask_done; afterwards m_tready=0, km_tvalid=0.
REQ-018 Mask tlast in same cycle as B tlast SHALL be accepted; WAIT_RES entered with mask_done=1.
REQ-019 WAIT_RES: r_tready = mask_done; r_tdata[0]=1 with r_tready=1 -> result_ptr <= r_tdata, -> DONE; r_tdata ignored in all other states.
REQ-020 DONE: done=1 for exactly one cycle, -> IDLE; start during DONE ignored.
REQ-021 cycles SHALL clear on start acceptance, increment each cycle while busy, saturate at all-ones, hold value after DONE until next start.
REQ-022 Zero-latency forwarding: operand throughput one token per cycle when source valid and kernel ready.
REQ-023 Single-token operand (tlast on first beat) SHALL be legal.

Reset
REQ-024 aresetn=0 at any edge, including mid-job, SHALL force IDLE, mask_done=0, busy=0, done=0, err=0, result_ptr=0, cycles=0, all tready=0, k_tvalid=0, km_tvalid=0.
REQ-025 Tokens in flight at reset are discarded; no output handshake in the reset cycle.

Configuration
REQ-026 Macro QTREE_SEQ_TIMEOUT_EN defined: when busy and cycles reaches TIMEOUT_CYCLES outside DONE -> ERR; ERR holds all tready/tvalid low, err=1, busy=1 until next cycle, then IDLE with err sticky; next accepted start clears err.
REQ-027 QTREE_SEQ_TIMEOUT_EN undefined: no watchdog, ERR unreachable, err tied 0.

Verification
REQ-028 A=3 tokens, B=2 tokens, mask=4 tokens, k_tready=1, result 0x00000105 two cycles after mask end -> k sees 5 beats, k_tlast on beats 3 and 5, result_ptr=0x105, done one pulse.
REQ-029 k_tready toggled 1010... during A/B -> token order/values preserved, no duplicates, a_tready/b_tready mirror k_tready.
REQ-030 B tlast and m tlast same cycle -> WAIT_RES next cycle, r_tready=1 immediately.
REQ-031 r_tdata[0]=1 asserted during SEND_B -> ignored; same value held into WAIT_RES -> captured.
REQ-032 aresetn=0 mid-SEND_B -> next cycle busy=0, all tready=0; new start runs full job correctly.
REQ-033 With macro, TIMEOUT_CYCLES=50, result never valid -> err=1 at cycle 50, return to IDLE; without macro same stimulus -> busy stays 1, err=0.

Source files
------------

// File: rtl/qtree_job_sequencer_if.sv
// Stream and control bundle for qtree_job_sequencer: operand A/B, mask, kernel,
// result and job control. slave = sequencer side, master = environment side.
interface qtree_job_sequencer_if #(
  parameter int DATA_W = 67,
  parameter int MASK_W = 67,
  parameter int PTR_W  = 32,
  parameter int CNT_W  = 32
);
  logic              start;
  logic              busy;
  logic              done;
  logic              err;

  logic [DATA_W-1:0] a_tdata;
  logic              a_tlast;
  logic              a_tvalid;
  logic              a_tready;

  logic [DATA_W-1:0] b_tdata;
  logic              b_tlast;
  logic              b_tvalid;
  logic              b_tready;

  logic [MASK_W-1:0] m_tdata;
  logic              m_tlast;
  logic              m_tvalid;
  logic              m_tready;

  logic [DATA_W-1:0] k_tdata;
  logic              k_tlast;
  logic              k_tvalid;
  logic              k_tready;

  logic [MASK_W-1:0] km_tdata;
  logic              km_tlast;
  logic              km_tvalid;
  logic              km_tready;

  logic [PTR_W-1:0]  r_tdata;
  logic              r_tready;

  logic [PTR_W-1:0]  result_ptr;
  logic [CNT_W-1:0]  cycles;

  modport slave (
    input  start,
    output busy, done, err,
    input  a_tdata, a_tlast, a_tvalid,
    output a_tready,
    input  b_tdata, b_tlast, b_tvalid,
    output b_tready,
    input  m_tdata, m_tlast, m_tvalid,
    output m_tready,
    output k_tdata, k_tlast, k_tvalid,
    input  k_tready,
    output km_tdata, km_tlast, km_tvalid,
    input  km_tready,
    input  r_tdata,
    output r_tready,
    output result_ptr, cycles
  );

  modport master (
    output start,
    input  busy, done, err,
    output a_tdata, a_tlast, a_tvalid,
    input  a_tready,
    output b_tdata, b_tlast, b_tvalid,
    input  b_tready,
    output m_tdata, m_tlast, m_tvalid,
    input  m_tready,
    input  k_tdata, k_tlast, k_tvalid,
    output k_tready,
    input  km_tdata, km_tlast, km_tvalid,
    output km_tready,
    output r_tdata,
    input  r_tready,
    input  result_ptr, cycles
  );
endinterface

// File: rtl/qtree_job_sequencer.sv
// Sequences one job: forwards tree A then tree B to the kernel, streams the mask
// alongside, then waits for a valid result. Optional watchdog: QTREE_SEQ_TIMEOUT_EN.
module qtree_job_sequencer #(
  parameter int DATA_W         = 67,
  parameter int MASK_W         = 67,
  parameter int PTR_W          = 32,
  parameter int CNT_W          = 32,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  qtree_job_sequencer_if.slave  bus
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_SEND_A   = 3'd1;
  localparam logic [2:0] S_SEND_B   = 3'd2;
  localparam logic [2:0] S_WAIT_RES = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;
  localparam logic [2:0] S_ERR      = 3'd5;

  logic [2:0]       state_q, state_d;
  logic             mask_done_q, mask_done_d;
  logic             err_q, err_d;
  logic [PTR_W-1:0] result_ptr_q, result_ptr_d;
  logic [CNT_W-1:0] cycles_q, cycles_d;

  logic sel_a;
  logic sel_b;
  logic in_job;
  logic mask_window;
  logic a_last_hs;
  logic b_last_hs;
  logic m_last_hs;
  logic res_hit;
  logic timeout_hit;

  // Every ready/valid is qualified by aresetn so nothing handshakes in a reset cycle.
  assign sel_a       = aresetn && (state_q == S_SEND_A);
  assign sel_b       = aresetn && (state_q == S_SEND_B);
  assign in_job      = (state_q == S_SEND_A) || (state_q == S_SEND_B) ||
                       (state_q == S_WAIT_RES);
  assign mask_window = aresetn && in_job && !mask_done_q;

  assign bus.k_tdata   = sel_b ? bus.b_tdata : bus.a_tdata;
  assign bus.k_tlast   = sel_b ? bus.b_tlast : bus.a_tlast;
  assign bus.k_tvalid  = (sel_a && bus.a_tvalid) || (sel_b && bus.b_tvalid);
  assign bus.a_tready  = sel_a && bus.k_tready;
  assign bus.b_tready  = sel_b && bus.k_tready;

  assign bus.km_tdata  = bus.m_tdata;
  assign bus.km_tlast  = bus.m_tlast;
  assign bus.km_tvalid = mask_window && bus.m_tvalid;
  assign bus.m_tready  = mask_window && bus.km_tready;

  assign bus.r_tready  = aresetn && (state_q == S_WAIT_RES) && mask_done_q;

  assign bus.busy       = (state_q != S_IDLE);
  assign bus.done       = (state_q == S_DONE);
  assign bus.err        = err_q;
  assign bus.result_ptr = result_ptr_q;
  assign bus.cycles     = cycles_q;

  assign a_last_hs = bus.a_tvalid && bus.a_tready && bus.a_tlast;
  assign b_last_hs = bus.b_tvalid && bus.b_tready && bus.b_tlast;
  assign m_last_hs = bus.m_tvalid && bus.m_tready && bus.m_tlast;
  assign res_hit   = bus.r_tready && bus.r_tdata[0];

`ifdef QTREE_SEQ_TIMEOUT_EN
  // DONE and ERR are already on their way out, so the watchdog only covers the job proper.
  assign timeout_hit = in_job && (cycles_q >= CNT_W'(TIMEOUT_CYCLES));
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout_hit    = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    mask_done_d  = mask_done_q;
    err_d        = err_q;
    result_ptr_d = result_ptr_q;
    cycles_d     = cycles_q;

    if (state_q != S_IDLE && !(&cycles_q)) begin
      cycles_d = cycles_q + CNT_W'(1);
    end
    if (m_last_hs) begin
      mask_done_d = 1'b1;
    end

    if (timeout_hit) begin
      state_d = S_ERR;
      err_d   = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_d     = S_SEND_A;
            cycles_d    = '0;
            err_d       = 1'b0;
            mask_done_d = 1'b0;
          end
        end
        S_SEND_A: begin
          if (a_last_hs) state_d = S_SEND_B;
        end
        S_SEND_B: begin
          if (b_last_hs) state_d = S_WAIT_RES;
        end
        S_WAIT_RES: begin
          if (res_hit) begin
            result_ptr_d = bus.r_tdata;
            state_d      = S_DONE;
          end
        end
        S_DONE:  state_d = S_IDLE;
        S_ERR:   state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q      <= S_IDLE;
      mask_done_q  <= 1'b0;
      err_q        <= 1'b0;
      result_ptr_q <= '0;
      cycles_q     <= '0;
    end else begin
      state_q      <= state_d;
      mask_done_q  <= mask_done_d;
      err_q        <= err_d;
      result_ptr_q <= result_ptr_d;
      cycles_q     <= cycles_d;
    end
  end

endmodule

// File: tb/tb_qtree_job_sequencer.sv
// Randomized bench for qtree_job_sequencer: per-job scoreboard of kernel/mask beats,
// result capture, done pulse, latency counter, reset and watchdog behaviour.
`timescale 1ns/1ps
module tb_qtree_job_sequencer;
  localparam int DW = 67;
  localparam int MW = 67;
  localparam int PW = 32;
  localparam int CW = 32;
  localparam int TO = 50;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  qtree_job_sequencer_if #(.DATA_W(DW), .MASK_W(MW), .PTR_W(PW), .CNT_W(CW)) bus ();

  qtree_job_sequencer #(
    .DATA_W(DW), .MASK_W(MW), .PTR_W(PW), .CNT_W(CW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .aclk(aclk),
    .aresetn(aresetn),
    .bus(bus)
  );

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] a_vals[$];
  logic [DW-1:0] b_vals[$];
  logic [MW-1:0] m_vals[$];
  logic [DW:0]   exp_k[$];
  logic [MW:0]   exp_km[$];
  logic [DW:0]   got_k[$];
  logic [MW:0]   got_km[$];
  logic [PW-1:0] res_val;

  int done_cnt, busy_cnt, order_bad, mirror_bad;
  int accept_iter, done_iter, blast_iter, mlast_iter;
  int err_cycles;
  bit err_seen, timed_out, rready_after_blast, err_at_start, rst_cycle_bad;

  task automatic drive_idle();
    bus.start = 1'b0;
    bus.a_tdata = '0; bus.a_tlast = 1'b0; bus.a_tvalid = 1'b0;
    bus.b_tdata = '0; bus.b_tlast = 1'b0; bus.b_tvalid = 1'b0;
    bus.m_tdata = '0; bus.m_tlast = 1'b0; bus.m_tvalid = 1'b0;
    bus.k_tready = 1'b0; bus.km_tready = 1'b0;
    bus.r_tdata = '0;
  endtask

  // Reference model: kernel sees all of A then all of B, tlast closing each tree.
  task automatic gen_job(input int na, input int nb, input int nm);
    logic [95:0] w;
    a_vals.delete(); b_vals.delete(); m_vals.delete();
    exp_k.delete(); exp_km.delete();
    for (int i = 0; i < na; i++) begin w = {$urandom(), $urandom(), $urandom()}; a_vals.push_back(w[DW-1:0]); end
    for (int i = 0; i < nb; i++) begin w = {$urandom(), $urandom(), $urandom()}; b_vals.push_back(w[DW-1:0]); end
    for (int i = 0; i < nm; i++) begin w = {$urandom(), $urandom(), $urandom()}; m_vals.push_back(w[MW-1:0]); end
    for (int i = 0; i < na; i++) exp_k.push_back({i == na - 1, a_vals[i]});
    for (int i = 0; i < nb; i++) exp_k.push_back({i == nb - 1, b_vals[i]});
    for (int i = 0; i < nm; i++) exp_km.push_back({i == nm - 1, m_vals[i]});
    res_val = $urandom() | 32'd1;
  endtask

  // kmode: 0 ready always, 1 toggle 1010..., 2 random. vmode: 0 valid always, 1 random.
  task automatic run_job(input int kmode, input int vmode, input int res_delay, input bit early,
                         input bit never_res, input bit abort_in_b, input int budget);
    int na, nb, nm, ai, bi, mi, it, since_mask;
    bit av, bv, mv, started, tog;
    na = a_vals.size(); nb = b_vals.size(); nm = m_vals.size();
    ai = 0; bi = 0; mi = 0; it = 0; since_mask = -1;
    av = 0; bv = 0; mv = 0; started = 0; tog = 1;
    got_k.delete(); got_km.delete();
    done_cnt = 0; busy_cnt = 0; order_bad = 0; mirror_bad = 0;
    accept_iter = -1; done_iter = -1; blast_iter = -1; mlast_iter = -1;
    err_cycles = 0; err_seen = 0; timed_out = 0; rready_after_blast = 0; err_at_start = 0;
    forever begin
      @(negedge aclk);
      if (started) begin
        if (!bus.busy) break;
        busy_cnt++;
        if (busy_cnt == 1) err_at_start = bus.err;
        if (bus.done) begin done_cnt++; done_iter = it; end
        if (bus.err && !err_seen) begin err_seen = 1; err_cycles = int'(bus.cycles); end
      end
      if (it >= budget) begin timed_out = 1; break; end
      if (abort_in_b && bi > 0 && bi < nb) begin
        aresetn = 1'b0;
        #1;
        rst_cycle_bad = bus.a_tready | bus.b_tready | bus.m_tready | bus.k_tvalid |
                        bus.km_tvalid | bus.r_tready;
        return;
      end
      bus.start = !started ? 1'b1 : (bus.busy ? 1'($urandom_range(0, 1)) : 1'b0);
      if (!av && ai < na) av = (vmode == 0) || ($urandom_range(0, 7) != 0);
      if (!bv && bi < nb) bv = (vmode == 0) || ($urandom_range(0, 7) != 0);
      if (!mv && mi < nm) mv = (vmode == 0) || ($urandom_range(0, 7) != 0);
      bus.a_tvalid = av; bus.a_tdata = (ai < na) ? a_vals[ai] : '0; bus.a_tlast = (ai == na - 1);
      bus.b_tvalid = bv; bus.b_tdata = (bi < nb) ? b_vals[bi] : '0; bus.b_tlast = (bi == nb - 1);
      bus.m_tvalid = mv; bus.m_tdata = (mi < nm) ? m_vals[mi] : '0; bus.m_tlast = (mi == nm - 1);
      case (kmode)
        0: bus.k_tready = 1'b1;
        1: begin bus.k_tready = tog; tog = ~tog; end
        default: bus.k_tready = ($urandom_range(0, 3) != 0);
      endcase
      bus.km_tready = (vmode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      if (mi == nm) since_mask++;
      if (!never_res && (early || since_mask >= res_delay)) bus.r_tdata = res_val;
      else bus.r_tdata = $urandom() & ~32'd1;
      #1;
      if (bus.r_tready && (ai < na || bi < nb || mi < nm)) order_bad++;
      if (bus.r_tready && blast_iter >= 0 && it == blast_iter + 1) rready_after_blast = 1;
      if (bus.r_tready && bus.r_tdata[0]) accept_iter = it;
      if ((bus.a_tready || bus.b_tready) && !bus.k_tready) mirror_bad++;
      if (bus.a_tready && bus.b_tready) mirror_bad++;
      if ((bus.k_tvalid && bus.k_tready) !=
          ((bus.a_tvalid && bus.a_tready) || (bus.b_tvalid && bus.b_tready))) mirror_bad++;
      if (bus.k_tvalid && bus.k_tready) got_k.push_back({bus.k_tlast, bus.k_tdata});
      if (bus.km_tvalid && bus.km_tready) got_km.push_back({bus.km_tlast, bus.km_tdata});
      if (bus.a_tvalid && bus.a_tready) begin ai++; av = 0; end
      if (bus.b_tvalid && bus.b_tready) begin bi++; bv = 0; if (bi == nb) blast_iter = it; end
      if (bus.m_tvalid && bus.m_tready) begin mi++; mv = 0; if (mi == nm) mlast_iter = it; end
      started = 1;
      it++;
    end
    drive_idle();
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    bus.start = 1'b1; bus.a_tvalid = 1'b1; bus.b_tvalid = 1'b1; bus.m_tvalid = 1'b1;
    bus.k_tready = 1'b1; bus.km_tready = 1'b1; bus.r_tdata = 32'h0000_0105;
    repeat (3) @(negedge aclk);
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0) begin
      failures++; $display("FAIL reset_flags: busy=%b done=%b err=%b required 0/0/0", bus.busy, bus.done, bus.err);
    end
    checks++;
    if (bus.cycles !== '0 || bus.result_ptr !== '0) begin
      failures++; $display("FAIL reset_regs: cycles=%0d result_ptr=%h required 0/0", bus.cycles, bus.result_ptr);
    end
    checks++;
    if ({bus.a_tready, bus.b_tready, bus.m_tready, bus.r_tready, bus.k_tvalid, bus.km_tvalid} !== 6'b0) begin
      failures++; $display("FAIL reset_handshake: a/b/m/r_tready,k/km_tvalid=%b required 000000",
        {bus.a_tready, bus.b_tready, bus.m_tready, bus.r_tready, bus.k_tvalid, bus.km_tvalid});
    end
    drive_idle();
    aresetn = 1'b1;
    repeat (2) @(negedge aclk);
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++; $display("FAIL idle_after_reset: busy=%b required 0", bus.busy);
    end
    $display("test_reset done");
  endtask

  task automatic test_basic_job();
    gen_job(3, 2, 4);
    res_val = 32'h0000_0105;
    run_job(0, 0, 2, 0, 0, 0, 200);
    checks++;
    if (got_k.size() != 5) begin
      failures++; $display("FAIL basic_kbeats: got %0d required 5", got_k.size());
    end else begin
      checks++;
      if ({got_k[4][DW], got_k[3][DW], got_k[2][DW], got_k[1][DW], got_k[0][DW]} !== 5'b10100) begin
        failures++; $display("FAIL basic_klast: got %b required 10100",
          {got_k[4][DW], got_k[3][DW], got_k[2][DW], got_k[1][DW], got_k[0][DW]});
      end
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (got_k[i] !== exp_k[i]) begin
          failures++; $display("FAIL basic_kbeat%0d: got %h required %h", i, got_k[i], exp_k[i]);
        end
      end
    end
    checks++;
    if (bus.result_ptr !== 32'h0000_0105) begin
      failures++; $display("FAIL basic_result: got %h required 00000105", bus.result_ptr);
    end
    checks++;
    if (done_cnt != 1 || done_iter != accept_iter + 1) begin
      failures++; $display("FAIL basic_done: pulses=%0d at iter %0d required 1 at iter %0d", done_cnt, done_iter, accept_iter + 1);
    end
    checks++;
    if (int'(bus.cycles) != busy_cnt) begin
      failures++; $display("FAIL basic_cycles: got %0d required %0d", bus.cycles, busy_cnt);
    end
    $display("test_basic_job: kbeats=%0d result=%h cycles=%0d", got_k.size(), bus.result_ptr, bus.cycles);
  endtask

  task automatic test_random_jobs();
    int bad;
    for (int j = 0; j < 20; j++) begin
      gen_job($urandom_range(1, 4), $urandom_range(1, 4), $urandom_range(1, 5));
      run_job(2, 1, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 0, 0, 400);
      bad = (got_k.size() != exp_k.size()) ? 0 : -1;
      for (int i = 0; i < got_k.size() && bad < 0; i++) if (got_k[i] !== exp_k[i]) bad = i;
      checks++;
      if (bad >= 0) begin
        failures++; $display("FAIL rand%0d_kseq: %0d beats, first bad index %0d, required %0d beats", j, got_k.size(), bad, exp_k.size());
      end
      bad = (got_km.size() != exp_km.size()) ? 0 : -1;
      for (int i = 0; i < got_km.size() && bad < 0; i++) if (got_km[i] !== exp_km[i]) bad = i;
      checks++;
      if (bad >= 0) begin
        failures++; $display("FAIL rand%0d_kmseq: %0d beats, first bad index %0d, required %0d beats", j, got_km.size(), bad, exp_km.size());
      end
      checks++;
      if (timed_out || bus.result_ptr !== res_val || done_cnt != 1) begin
        failures++; $display("FAIL rand%0d_result: ptr=%h done=%0d stuck=%0d required ptr=%h done=1 stuck=0", j, bus.result_ptr, done_cnt, timed_out, res_val);
      end
      checks++;
      if (order_bad != 0 || mirror_bad != 0 || int'(bus.cycles) != busy_cnt) begin
        failures++; $display("FAIL rand%0d_protocol: order_bad=%0d mirror_bad=%0d cycles=%0d required 0/0/%0d", j, order_bad, mirror_bad, bus.cycles, busy_cnt);
      end
      $display("test_random_jobs %0d: kbeats=%0d mbeats=%0d result=%h cycles=%0d", j, got_k.size(), got_km.size(), bus.result_ptr, bus.cycles);
    end
  endtask

  task automatic test_backpressure_toggle();
    int bad;
    gen_job(4, 3, 3);
    run_job(1, 0, 0, 0, 0, 0, 300);
    bad = (got_k.size() != exp_k.size()) ? 0 : -1;
    for (int i = 0; i < got_k.size() && bad < 0; i++) if (got_k[i] !== exp_k[i]) bad = i;
    checks++;
    if (bad >= 0) begin
      failures++; $display("FAIL toggle_kseq: %0d beats, first bad index %0d, required %0d beats", got_k.size(), bad, exp_k.size());
    end
    checks++;
    if (mirror_bad != 0) begin
      failures++; $display("FAIL toggle_mirror: %0d ready mismatches required 0", mirror_bad);
    end
    checks++;
    if (bus.result_ptr !== res_val) begin
      failures++; $display("FAIL toggle_result: got %h required %h", bus.result_ptr, res_val);
    end
    $display("test_backpressure_toggle: kbeats=%0d result=%h", got_k.size(), bus.result_ptr);
  endtask

  task automatic test_same_cycle_last();
    gen_job(2, 3, 5);
    run_job(0, 0, 0, 0, 0, 0, 200);
    checks++;
    if (mlast_iter != blast_iter || blast_iter < 0) begin
      failures++; $display("FAIL samelast_align: mask last iter %0d required B last iter %0d", mlast_iter, blast_iter);
    end
    checks++;
    if (!rready_after_blast) begin
      failures++; $display("FAIL samelast_rready: r_tready=0 after B/mask last, required 1");
    end
    checks++;
    if (got_km.size() != 5 || bus.result_ptr !== res_val) begin
      failures++; $display("FAIL samelast_job: mbeats=%0d ptr=%h required 5/%h", got_km.size(), bus.result_ptr, res_val);
    end
    $display("test_same_cycle_last: blast=%0d mlast=%0d result=%h", blast_iter, mlast_iter, bus.result_ptr);
  endtask

  task automatic test_early_result();
    gen_job(2, 3, 1);
    run_job(0, 0, 0, 1, 0, 0, 200);
    checks++;
    if (order_bad != 0 || accept_iter != blast_iter + 1) begin
      failures++; $display("FAIL early_accept: accept iter %0d order_bad=%0d required iter %0d and 0", accept_iter, order_bad, blast_iter + 1);
    end
    checks++;
    if (bus.result_ptr !== res_val) begin
      failures++; $display("FAIL early_result: got %h required %h", bus.result_ptr, res_val);
    end
    $display("test_early_result: accept=%0d result=%h", accept_iter, bus.result_ptr);
  endtask

  task automatic test_reset_mid_job();
    int bad;
    gen_job(2, 4, 3);
    bus.r_tdata = '0;
    run_job(0, 0, 0, 0, 0, 1, 200);
    checks++;
    if (rst_cycle_bad) begin
      failures++; $display("FAIL midreset_cycle: handshake signal high while aresetn=0, required all 0");
    end
    @(negedge aclk);
    aresetn = 1'b1;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || {bus.a_tready, bus.b_tready, bus.m_tready, bus.k_tvalid} !== 4'b0 ||
        bus.cycles !== '0 || bus.result_ptr !== '0) begin
      failures++; $display("FAIL midreset_after: busy=%b readies/kvalid=%b cycles=%0d ptr=%h required 0/0000/0/0",
        bus.busy, {bus.a_tready, bus.b_tready, bus.m_tready, bus.k_tvalid}, bus.cycles, bus.result_ptr);
    end
    drive_idle();
    gen_job(3, 3, 2);
    run_job(0, 0, 1, 0, 0, 0, 200);
    bad = (got_k.size() != exp_k.size()) ? 0 : -1;
    for (int i = 0; i < got_k.size() && bad < 0; i++) if (got_k[i] !== exp_k[i]) bad = i;
    checks++;
    if (bad >= 0 || bus.result_ptr !== res_val || done_cnt != 1) begin
      failures++; $display("FAIL midreset_rerun: kbeats=%0d bad=%0d ptr=%h done=%0d required %0d/-1/%h/1",
        got_k.size(), bad, bus.result_ptr, done_cnt, exp_k.size(), res_val);
    end
    $display("test_reset_mid_job: rerun kbeats=%0d result=%h", got_k.size(), bus.result_ptr);
  endtask

  task automatic test_timeout();
    gen_job(2, 2, 2);
`ifdef QTREE_SEQ_TIMEOUT_EN
    run_job(0, 0, 0, 0, 1, 0, 200);
    checks++;
    if (!err_seen || err_cycles < TO || err_cycles > TO + 2 || timed_out || done_cnt != 0) begin
      failures++; $display("FAIL timeout_err: seen=%0d cycles=%0d stuck=%0d done=%0d required 1/%0d..%0d/0/0",
        err_seen, err_cycles, timed_out, done_cnt, TO, TO + 2);
    end
    repeat (2) @(negedge aclk);
    checks++;
    if (bus.err !== 1'b1 || bus.busy !== 1'b0) begin
      failures++; $display("FAIL timeout_sticky: err=%b busy=%b required 1/0", bus.err, bus.busy);
    end
    gen_job(1, 1, 1);
    run_job(0, 0, 0, 0, 0, 0, 200);
    checks++;
    if (err_at_start !== 1'b0 || bus.err !== 1'b0 || bus.result_ptr !== res_val) begin
      failures++; $display("FAIL timeout_clear: err_at_start=%b err=%b ptr=%h required 0/0/%h", err_at_start, bus.err, bus.result_ptr, res_val);
    end
    $display("test_timeout: err at cycles=%0d, next job result=%h", err_cycles, bus.result_ptr);
`else
    run_job(0, 0, 0, 0, 1, 0, 120);
    checks++;
    if (!timed_out || bus.busy !== 1'b1 || err_seen || bus.err !== 1'b0) begin
      failures++; $display("FAIL nowatchdog: stuck=%0d busy=%b err_seen=%0d err=%b required 1/1/0/0", timed_out, bus.busy, err_seen, bus.err);
    end
    aresetn = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    $display("test_timeout: watchdog absent, busy held for %0d cycles", busy_cnt);
`endif
  endtask

  initial begin
    drive_idle();
    rst_cycle_bad = 0;
    test_reset();
    test_basic_job();
    test_backpressure_toggle();
    test_same_cycle_last();
    test_early_result();
    test_random_jobs();
    test_reset_mid_job();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_time_limit: simulation still running at %0t, required completion", $time);
    $fatal(1);
  end
endmodule
